// File: rtl/obstacle_gen_pkg.sv
// Shared screen geometry, obstacle bus layout and game-mode encoding
// used by the obstacle generator, pixel stage and player logic.
package obstacle_gen_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int N_OBS    = 10;
    localparam int OBS_XW   = 20;
    localparam int OBS_YW   = 18;

    typedef enum logic [1:0] {
        MODE_INIT  = 2'b00,
        MODE_RUN   = 2'b01,
        MODE_PAUSE = 2'b10,
        MODE_OVER  = 2'b11
    } gamemode_e;

    // 16-bit Galois LFSR step, right shift, taps 16'hB400
    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return q[0] ? ((q >> 1) ^ 16'hB400) : (q >> 1);
    endfunction

endpackage

// File: rtl/obstacle_lfsr.sv
// 16-bit Galois LFSR supplying random obstacle size and side.
module obstacle_lfsr
    import obstacle_gen_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    output logic [15:0] q
);

    logic [15:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= SEED;
        end else if (clr) begin
            r_q <= SEED;
        end else if (en) begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/obstacle_gen.sv
// Obstacle slot storage: scrolls obstacles left each running frame and
// spawns new ones at the right edge on a fixed frame schedule.
module obstacle_gen
    import obstacle_gen_pkg::*;
#(
    parameter int          SPEED        = 2,
    parameter int          SPAWN_FRAMES = 90,
    parameter int          MIN_W        = 20,
    parameter int          MIN_H        = 40,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        frame_tick,
    input  logic [1:0]                  gamemode,
    output logic [N_OBS*OBS_XW-1:0]     obstacle_x,
    output logic [N_OBS*OBS_YW-1:0]     obstacle_y,
    output logic                        passed
);

    localparam int             CW       = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(SPAWN_FRAMES - 1);
    localparam logic [9:0]     SPD      = 10'(SPEED);

    logic [9:0]    r_left  [N_OBS];
    logic [9:0]    r_right [N_OBS];
    logic [8:0]    r_top   [N_OBS];
    logic [8:0]    r_bot   [N_OBS];
    logic [CW-1:0] r_cnt;
    logic          r_passed;

    logic [9:0]    w_nl [N_OBS];
    logic [9:0]    w_nr [N_OBS];
    logic [8:0]    w_nt [N_OBS];
    logic [8:0]    w_nb [N_OBS];
    logic [15:0]   w_lfsr;
    gamemode_e     w_mode;
    logic          w_clear;
    logic          w_run_tick;
    logic          w_found;
    logic [3:0]    w_slot;
    logic          w_spawn;
    logic          w_any_exit;
    logic [9:0]    w_sp_right;
    logic [8:0]    w_sp_h;
    logic          w_unused_lfsr;

    assign w_mode        = gamemode_e'(gamemode);
    assign w_clear       = (w_mode == MODE_INIT);
    assign w_run_tick    = (w_mode == MODE_RUN) && frame_tick;
    assign w_sp_right    = 10'(SCREEN_W) + 10'(MIN_W) + {4'b0, w_lfsr[5:0]};
    assign w_sp_h        = 9'(MIN_H) + {2'b0, w_lfsr[12:6]};
    assign w_unused_lfsr = ^w_lfsr[14:13];

    obstacle_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clear),
        .en    (w_run_tick),
        .q     (w_lfsr)
    );

    // Spawn target is chosen from the pre-scroll free map, so a slot that
    // exits this tick is only reused on a later attempt.
    always_comb begin
        w_found    = 1'b0;
        w_slot     = '0;
        w_any_exit = 1'b0;
        for (int unsigned i = 0; i < N_OBS; i++) begin
            if (!w_found && (r_left[i] == r_right[i]) && (r_top[i] == r_bot[i])) begin
                w_found = 1'b1;
                w_slot  = 4'(i);
            end
        end
        w_spawn = w_run_tick && (r_cnt == CNT_LAST) && w_found;

        for (int unsigned i = 0; i < N_OBS; i++) begin
            w_nl[i] = r_left[i];
            w_nr[i] = r_right[i];
            w_nt[i] = r_top[i];
            w_nb[i] = r_bot[i];
            if (!((r_left[i] == r_right[i]) && (r_top[i] == r_bot[i]))) begin
                if (r_right[i] <= SPD) begin
                    w_nl[i]    = '0;
                    w_nr[i]    = '0;
                    w_nt[i]    = '0;
                    w_nb[i]    = '0;
                    w_any_exit = 1'b1;
                end else begin
                    w_nr[i] = r_right[i] - SPD;
                    w_nl[i] = (r_left[i] > SPD) ? (r_left[i] - SPD) : '0;
                end
            end
            if (w_spawn && (w_slot == 4'(i))) begin
                w_nl[i] = 10'(SCREEN_W);
                w_nr[i] = w_sp_right;
                if (w_lfsr[15]) begin
                    w_nt[i] = '0;
                    w_nb[i] = w_sp_h;
                end else begin
                    w_nt[i] = 9'(SCREEN_H) - w_sp_h;
                    w_nb[i] = 9'(SCREEN_H);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_OBS; i++) begin
                r_left[i]  <= '0;
                r_right[i] <= '0;
                r_top[i]   <= '0;
                r_bot[i]   <= '0;
            end
            r_cnt    <= '0;
            r_passed <= 1'b0;
        end else if (w_clear) begin
            for (int unsigned i = 0; i < N_OBS; i++) begin
                r_left[i]  <= '0;
                r_right[i] <= '0;
                r_top[i]   <= '0;
                r_bot[i]   <= '0;
            end
            r_cnt    <= '0;
            r_passed <= 1'b0;
        end else if (w_run_tick) begin
            for (int unsigned i = 0; i < N_OBS; i++) begin
                r_left[i]  <= w_nl[i];
                r_right[i] <= w_nr[i];
                r_top[i]   <= w_nt[i];
                r_bot[i]   <= w_nb[i];
            end
            r_cnt    <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
            r_passed <= w_any_exit;
        end else begin
            r_passed <= 1'b0;
        end
    end

    always_comb begin
        obstacle_x = '0;
        obstacle_y = '0;
        for (int unsigned i = 0; i < N_OBS; i++) begin
            obstacle_x[i*OBS_XW +: OBS_XW] = {r_right[i], r_left[i]};
            obstacle_y[i*OBS_YW +: OBS_YW] = {r_bot[i], r_top[i]};
        end
    end

    assign passed = r_passed;

endmodule

// File: tb/tb_obstacle_gen.sv
// Directed bench for obstacle_gen: reference model feeds a scoreboard
// queue, plus fixed-value checks for the first spawn and mode behaviour.
module tb_obstacle_gen;

    localparam int          SPEED = 2;
    localparam int          SPAWN = 4;
    localparam int          MIN_W = 20;
    localparam int          MIN_H = 40;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         frame_tick = 1'b0;
    logic [1:0]   gamemode = 2'b00;
    logic [199:0] obstacle_x;
    logic [179:0] obstacle_y;
    logic         passed;

    typedef struct packed {
        logic [199:0] x;
        logic [179:0] y;
        logic         p;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;

    int          m_l[10];
    int          m_r[10];
    int          m_t[10];
    int          m_b[10];
    int          m_cnt;
    logic [15:0] m_lfsr;
    logic        m_p;

    obstacle_gen #(
        .SPEED        (SPEED),
        .SPAWN_FRAMES (SPAWN),
        .MIN_W        (MIN_W),
        .MIN_H        (MIN_H),
        .SEED         (SEED)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .gamemode   (gamemode),
        .obstacle_x (obstacle_x),
        .obstacle_y (obstacle_y),
        .passed     (passed)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int i = 0; i < 10; i++) begin
            m_l[i] = 0; m_r[i] = 0; m_t[i] = 0; m_b[i] = 0;
        end
        m_cnt  = 0;
        m_lfsr = SEED;
        m_p    = 1'b0;
    endfunction

    function automatic void model_step(input bit tk, input logic [1:0] mode);
        int slot;
        int h;
        bit any;
        bit freev[10];
        slot = -1;
        any  = 1'b0;
        if (mode == 2'b00) begin
            model_clear();
        end else if (mode == 2'b01 && tk) begin
            for (int i = 0; i < 10; i++) begin
                freev[i] = (m_l[i] == 0) && (m_r[i] == 0) && (m_t[i] == 0) && (m_b[i] == 0);
                if (slot < 0 && freev[i]) slot = i;
            end
            for (int i = 0; i < 10; i++) begin
                if (!freev[i]) begin
                    if (m_r[i] <= SPEED) begin
                        m_l[i] = 0; m_r[i] = 0; m_t[i] = 0; m_b[i] = 0;
                        any = 1'b1;
                    end else begin
                        m_r[i] = m_r[i] - SPEED;
                        m_l[i] = (m_l[i] > SPEED) ? m_l[i] - SPEED : 0;
                    end
                end
            end
            if (m_cnt == SPAWN - 1) begin
                m_cnt = 0;
                if (slot >= 0) begin
                    h = MIN_H + int'((m_lfsr >> 6) & 16'h7F);
                    m_l[slot] = 640;
                    m_r[slot] = 640 + MIN_W + int'(m_lfsr & 16'h3F);
                    if (m_lfsr[15]) begin
                        m_t[slot] = 0;   m_b[slot] = h;
                    end else begin
                        m_t[slot] = 480 - h; m_b[slot] = 480;
                    end
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
            m_p = any;
        end else begin
            m_p = 1'b0;
        end
    endfunction

    function automatic exp_t model_pack();
        exp_t e;
        e = '0;
        for (int i = 0; i < 10; i++) begin
            e.x[i*20 +: 20] = {10'(m_r[i]), 10'(m_l[i])};
            e.y[i*18 +: 18] = {9'(m_b[i]), 9'(m_t[i])};
        end
        e.p = m_p;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_head();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk("sb_x", obstacle_x, e.x);
            chk("sb_y", 200'(obstacle_y), 200'(e.y));
            chk("sb_passed", 200'(passed), 200'(e.p));
        end
    endtask

    task automatic cycle(input bit tk, input logic [1:0] mode);
        @(negedge clk);
        frame_tick = tk;
        gamemode   = mode;
        model_step(tk, mode);
        sb.push_back(model_pack());
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        check_head();
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            cycle(1'b1, 2'b01);
            cycle(1'b0, 2'b01);
        end
    endtask

    task automatic chk_first_spawn(input string tag);
        chk({tag, "_x0"}, 200'(obstacle_x[19:0]), 200'({10'd688, 10'd640}));
        chk({tag, "_y0"}, 200'(obstacle_y[17:0]), 200'({9'd480, 9'd342}));
        chk({tag, "_rest"}, 200'(obstacle_x[199:20]), '0);
    endtask

    initial begin
        logic [199:0] occ;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_x", obstacle_x, '0);
        chk("rst_y", 200'(obstacle_y), '0);
        chk("rst_passed", 200'(passed), '0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 2'b00);

        ticks(3);
        chk("pre_spawn_x", obstacle_x, '0);
        ticks(1);
        chk_first_spawn("first");
        ticks(1);
        chk("scroll_x0", 200'(obstacle_x[19:0]), 200'({10'd686, 10'd638}));

        repeat (5) cycle(1'b1, 2'b10);
        repeat (5) cycle(1'b1, 2'b11);
        chk("pause_x0", 200'(obstacle_x[19:0]), 200'({10'd686, 10'd638}));
        ticks(3);
        chk("sched_x1_left", 200'(obstacle_x[29:20]), 200'(10'd640));

        cycle(1'b1, 2'b00);
        chk("clear_x", obstacle_x, '0);
        chk("clear_y", 200'(obstacle_y), '0);
        ticks(4);
        chk_first_spawn("respawn");

        ticks(36);
        occ = '0;
        for (int i = 0; i < 10; i++)
            occ[i] = (obstacle_x[i*20 +: 20] == '0) && (obstacle_y[i*18 +: 18] == '0);
        chk("full_free_map", occ, '0);
        ticks(4);
        chk("full_x0_scrolled", 200'(obstacle_x[9:0]), 200'(10'd560));

        ticks(360);

        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_x", obstacle_x, '0);
        chk("async_rst_y", 200'(obstacle_y), '0);
        chk("async_rst_passed", 200'(passed), '0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        ticks(3);
        chk("post_rst_pre_x", obstacle_x, '0);
        ticks(1);
        chk_first_spawn("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
